pcieifc_sync_fifo_fwft: RTL and testbench

Parametrised single-clock first-word-fall-through FIFO for the PCIe interface datapath. It is the general-purpose successor to the fixed-geometry synchronous FIFOs and any width/depth is legal. It adds a bypassed registered output stage, an occupancy count, programmable almost-full/almost-empty flags and optional overflow/underflow error capture. Producers and consumers inside the PCIe interface use it wherever a small elastic buffer with one-cycle first-word latency and sustained one-per-clock throughput is needed.

---
 rtl/pcieifc_fifo_pkg.sv | 31 +++
 rtl/pcieifc_sfifo_ram.sv | 35 +++
 rtl/pcieifc_sync_fifo_fwft.sv | 177 +++++++++++++++++
 tb/tb_pcieifc_sync_fifo_fwft.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcieifc_fifo_pkg.sv
// Shared definitions for the PCIe interface FIFOs: geometry helpers,
// default thresholds and parameter legality checks.
package pcieifc_fifo_pkg;

    localparam int DEF_DSIZE     = 8;
    localparam int DEF_ASIZE     = 4;
    localparam int DEF_AEMPTY_TH = 1;

    // Total capacity: every RAM entry plus the output register.
    function automatic int fifo_depth(input int asize);
        return (1 << asize) + 1;
    endfunction

    // Default almost-full threshold: one below the RAM size.
    function automatic int def_afull_th(input int asize);
        return (1 << asize) - 1;
    endfunction

    function automatic bit geometry_ok(input int dsize, input int asize);
        return (dsize >= 1) && (asize >= 1);
    endfunction

    function automatic bit afull_th_ok(input int asize, input int th);
        return (th >= 1) && (th <= fifo_depth(asize));
    endfunction

    function automatic bit aempty_th_ok(input int asize, input int th);
        return (th >= 0) && (th <= fifo_depth(asize) - 1);
    endfunction

endpackage

// File: rtl/pcieifc_sfifo_ram.sv
// Simple dual-port storage for pcieifc_sync_fifo_fwft: one write port, one
// read port with a registered, read-first output. Written to map onto block
// or distributed RAM.
module pcieifc_sfifo_ram #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Write port and registered read port; a same-slot read returns the old word.
    // NOTE: the array and its read register carry no reset, otherwise the tools
    // cannot map them onto RAM primitives; the FIFO control never exposes
    // an unwritten word as valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pcieifc_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with a bypassable output stage,
// occupancy count and almost-full/almost-empty flags.
// Optional sticky overflow/underflow capture: define PCIEIFC_SFIFO_ERR_CHK_EN.
module pcieifc_sync_fifo_fwft
    import pcieifc_fifo_pkg::*;
#(
    parameter int DSIZE     = DEF_DSIZE,
    parameter int ASIZE     = DEF_ASIZE,
    parameter int AFULL_TH  = def_afull_th(ASIZE),
    parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wen,
    input  logic [DSIZE-1:0] din,
    input  logic             ren,
    output logic [DSIZE-1:0] dout,
    output logic             full,
    output logic             afull,
    output logic             empty,
    output logic             aempty,
    output logic [ASIZE:0]   count
`ifdef PCIEIFC_SFIFO_ERR_CHK_EN
    ,
    output logic             ovf_err,
    output logic             udf_err
`endif
);

    localparam int             DEPTH     = fifo_depth(ASIZE);
    localparam logic [ASIZE:0] DEPTH_C   = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_C   = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_C  = (ASIZE+1)'(AEMPTY_TH);
    localparam logic [ASIZE:0] ONE_C     = (ASIZE+1)'(1);

    // Elaboration-time parameter checks.
    if (!geometry_ok(DSIZE, ASIZE)) begin : g_bad_geometry
        $error("pcieifc_sync_fifo_fwft: DSIZE and ASIZE must both be >= 1");
    end
    if (!afull_th_ok(ASIZE, AFULL_TH)) begin : g_bad_afull
        $error("pcieifc_sync_fifo_fwft: AFULL_TH must lie in 1..DEPTH");
    end
    if (!aempty_th_ok(ASIZE, AEMPTY_TH)) begin : g_bad_aempty
        $error("pcieifc_sync_fifo_fwft: AEMPTY_TH must lie in 0..DEPTH-1");
    end

    // Registered state and its next-state values.
    logic [ASIZE:0]   wptr_q, wptr_d;
    logic [ASIZE:0]   rptr_q, rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic             out_vld_q, out_vld_d;
    logic             byp_sel_q, byp_sel_d;     // head comes from bypass register
    logic [DSIZE-1:0] byp_data_q, byp_data_d;

    // Per-cycle decisions.
    logic             push_acc;
    logic             pop_acc;
    logic             ram_nempty;
    logic             load;
    logic             bypass;
    logic             ram_we;
    logic             ram_re;
    logic [DSIZE-1:0] ram_rdata;

    // Flags and count decode registered state only.
    assign count  = count_q;
    assign full   = (count_q == DEPTH_C);
    assign afull  = (count_q >= AFULL_C);
    assign empty  = (count_q == '0);
    assign aempty = (count_q <= AEMPTY_C);

    // Head word: either the RAM read register or the bypass register.
    assign dout = byp_sel_q ? byp_data_q : ram_rdata;

    // Accept/route decisions and next-state computation.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        push_acc   = wen & (~full | ren) & ~clr;
        pop_acc    = ren & ~empty & ~clr;
        ram_nempty = (wptr_q != rptr_q);
        load       = (pop_acc | ~out_vld_q) & ~clr;
        ram_re     = load & ram_nempty;
        bypass     = load & ~ram_nempty & push_acc;
        ram_we     = push_acc & ~bypass;

        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        out_vld_d  = out_vld_q;
        byp_sel_d  = byp_sel_q;
        byp_data_d = byp_data_q;

        if (clr) begin
            // dout keeps its stale value: the bypass path is left untouched.
            wptr_d    = '0;
            rptr_d    = '0;
            count_d   = '0;
            out_vld_d = 1'b0;
        end else begin
            if (ram_we) wptr_d = wptr_q + ONE_C;
            if (ram_re) rptr_d = rptr_q + ONE_C;
            if (load)   out_vld_d = ram_nempty | push_acc;
            if (ram_re) begin
                byp_sel_d = 1'b0;
            end else if (bypass) begin
                byp_sel_d  = 1'b1;
                byp_data_d = din;
            end
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset selects the zeroed bypass register so dout reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            out_vld_q  <= 1'b0;
            byp_sel_q  <= 1'b1;
            byp_data_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            out_vld_q  <= out_vld_d;
            byp_sel_q  <= byp_sel_d;
            byp_data_q <= byp_data_d;
        end
    end

    // The read is issued on the edge that advances rptr, so the RAM register
    // holds the new head right after a pop.
    pcieifc_sfifo_ram #(
        .DW (DSIZE),
        .AW (ASIZE)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wptr_q[ASIZE-1:0]),
        .wdata_i (din),
        .re_i    (ram_re),
        .raddr_i (rptr_q[ASIZE-1:0]),
        .rdata_o (ram_rdata)
    );

`ifdef PCIEIFC_SFIFO_ERR_CHK_EN
    logic ovf_q;
    logic udf_q;

    // Sticky capture of illegal push (full, no pop) and pop (empty).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (clr) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wen & full & ~ren) ovf_q <= 1'b1;
            if (ren & empty)       udf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`endif

endmodule

// File: tb/tb_pcieifc_sync_fifo_fwft.sv
// Self-checking bench for pcieifc_sync_fifo_fwft (DSIZE=8, ASIZE=2, DEPTH=5).
module tb_pcieifc_sync_fifo_fwft;

    localparam int DSIZE     = 8;
    localparam int ASIZE     = 2;
    localparam int DEPTH     = 5;
    localparam int AFULL_TH  = 4;
    localparam int AEMPTY_TH = 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr   = 1'b0;
    logic             wen   = 1'b0;
    logic             ren   = 1'b0;
    logic [DSIZE-1:0] din   = '0;
    logic [DSIZE-1:0] dout;
    logic             full, afull, empty, aempty;
    logic [ASIZE:0]   count;
`ifdef PCIEIFC_SFIFO_ERR_CHK_EN
    logic             ovf_err, udf_err;
`endif

    pcieifc_sync_fifo_fwft #(
        .DSIZE     (DSIZE),
        .ASIZE     (ASIZE),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .wen     (wen),
        .din     (din),
        .ren     (ren),
        .dout    (dout),
        .full    (full),
        .afull   (afull),
        .empty   (empty),
        .aempty  (aempty),
        .count   (count)
`ifdef PCIEIFC_SFIFO_ERR_CHK_EN
        ,
        .ovf_err (ovf_err),
        .udf_err (udf_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard and reference model state.
    logic [DSIZE-1:0] sb[$];
    bit               exp_ovf = 1'b0;
    bit               exp_udf = 1'b0;
    bit               hit;
    logic [DSIZE-1:0] pexp, pact;

    // One clock of stimulus: drive at the falling edge, update the model,
    // return #1 after the rising edge. hit/pexp/pact describe any pop.
    task automatic cycle(input bit w, input logic [DSIZE-1:0] d, input bit r, input bit c);
        bit m_full, m_empty;
        @(negedge clk);
        wen = w; din = d; ren = r; clr = c;
        hit = 1'b0;
        if (c) begin
            sb.delete();
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else begin
            m_full  = (sb.size() == DEPTH);
            m_empty = (sb.size() == 0);
            if (w && m_full && !r) exp_ovf = 1'b1;
            if (r && m_empty)      exp_udf = 1'b1;
            if (r && !m_empty) begin
                hit  = 1'b1;
                pexp = sb.pop_front();
                pact = dout;
            end
            if (w && (!m_full || r)) sb.push_back(d);
        end
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({dout, count, empty, aempty, full, afull} !== {8'h00, 3'd0, 4'b1100})
            begin bad++; $display("FAIL reset_outputs got dout=%h cnt=%0d e=%b ae=%b f=%b af=%b", dout, count, empty, aempty, full, afull); end
`ifdef PCIEIFC_SFIFO_ERR_CHK_EN
        total++;
        if ({ovf_err, udf_err} !== 2'b00) begin bad++; $display("FAIL reset_err got %b%b want 00", ovf_err, udf_err); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_word();
        cycle(1'b1, 8'hA1, 1'b0, 1'b0);
        total++;
        if ({empty, dout, count, aempty, afull} !== {1'b0, 8'hA1, 3'd1, 1'b1, 1'b0})
            begin bad++; $display("FAIL first_word got e=%b dout=%h cnt=%0d ae=%b af=%b want 0 a1 1 1 0", empty, dout, count, aempty, afull); end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        total++;
        if (!hit || pact !== pexp) begin bad++; $display("FAIL first_pop got %h want %h hit=%b", pact, pexp, hit); end
        total++;
        if (empty !== 1'b1) begin bad++; $display("FAIL first_empty got %b want 1", empty); end
    endtask

    task automatic test_fill_full();
        logic [ASIZE:0] ec;
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            ec = 3'(sb.size());
            total++;
            if ({count, full, afull} !== {ec, ec == 3'(DEPTH), ec >= 3'(AFULL_TH)})
                begin bad++; $display("FAIL fill_%0d got cnt=%0d f=%b af=%b want cnt=%0d", i, count, full, afull, ec); end
        end
        cycle(1'b1, 8'h06, 1'b0, 1'b0);
        total++;
        if ({count, full, dout} !== {3'd5, 1'b1, 8'h01})
            begin bad++; $display("FAIL overflow_drop got cnt=%0d f=%b dout=%h want 5 1 01", count, full, dout); end
`ifdef PCIEIFC_SFIFO_ERR_CHK_EN
        total++;
        if (ovf_err !== exp_ovf) begin bad++; $display("FAIL ovf_set got %b want %b", ovf_err, exp_ovf); end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            ec = 3'(sb.size());
            total++;
            if (!hit || pact !== pexp) begin bad++; $display("FAIL drain_data got %h want %h", pact, pexp); end
            total++;
            if ({count, empty, aempty, full} !== {ec, ec == 3'd0, ec <= 3'(AEMPTY_TH), 1'b0})
                begin bad++; $display("FAIL drain_flags got cnt=%0d e=%b ae=%b f=%b want cnt=%0d", count, empty, aempty, full, ec); end
        end
    endtask

    task automatic test_full_push_pop();
        logic [DSIZE-1:0] order [DEPTH];
        order = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h10};
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h10, 1'b1, 1'b0);
        total++;
        if (!hit || pact !== 8'h01) begin bad++; $display("FAIL fullpp_pop got %h want 01", pact); end
        total++;
        if ({dout, count, full} !== {8'h02, 3'd5, 1'b1})
            begin bad++; $display("FAIL fullpp_state got dout=%h cnt=%0d f=%b want 02 5 1", dout, count, full); end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            total++;
            if (!hit || pact !== pexp || pact !== order[i])
                begin bad++; $display("FAIL fullpp_drain_%0d got %h want %h", i, pact, order[i]); end
        end
        total++;
        if (empty !== 1'b1) begin bad++; $display("FAIL fullpp_empty got %b want 1", empty); end
    endtask

    task automatic test_back_to_back();
        int errs = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 8'(i), 1'b1, 1'b0);
            total++;
            if (hit && pact !== pexp) begin
                errs++; bad++; $display("FAIL stream_pop_%0d got %h want %h", i, pact, pexp);
            end
            total++;
            if (dout !== 8'(i) || count !== 3'(sb.size()) || count > 3'd1) begin
                errs++; bad++; $display("FAIL stream_state_%0d got dout=%h cnt=%0d want %h %0d", i, dout, count, 8'(i), sb.size());
            end
            if (errs > 8) break;
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        total++;
        if (!hit || pact !== 8'd99 || empty !== 1'b1)
            begin bad++; $display("FAIL stream_last got %h e=%b want 63 1", pact, empty); end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b1);
        total++;
        if ({count, empty, full, dout} !== {3'd0, 1'b1, 1'b0, 8'h30})
            begin bad++; $display("FAIL clr_state got cnt=%0d e=%b f=%b dout=%h want 0 1 0 30", count, empty, full, dout); end
`ifdef PCIEIFC_SFIFO_ERR_CHK_EN
        total++;
        if ({ovf_err, udf_err} !== 2'b00) begin bad++; $display("FAIL clr_err got %b%b want 00", ovf_err, udf_err); end
`endif
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        total++;
        if ({count, empty} !== {3'd0, 1'b1}) begin bad++; $display("FAIL udf_count got cnt=%0d e=%b want 0 1", count, empty); end
`ifdef PCIEIFC_SFIFO_ERR_CHK_EN
        total++;
        if (udf_err !== exp_udf) begin bad++; $display("FAIL udf_set got %b want %b", udf_err, exp_udf); end
`endif
    endtask

    task automatic test_async_reset();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
            if (pass == 1) begin
                cycle(1'b1, 8'h50, 1'b1, 1'b0);
                wen = 1'b1; din = 8'h51; ren = 1'b1;
            end
            #2 rst_n = 1'b0;
            #1;
            sb.delete(); exp_ovf = 1'b0; exp_udf = 1'b0;
            total++;
            if ({dout, count, empty, aempty, full, afull} !== {8'h00, 3'd0, 4'b1100})
                begin bad++; $display("FAIL async_rst_%0d got dout=%h cnt=%0d e=%b ae=%b f=%b af=%b", pass, dout, count, empty, aempty, full, afull); end
`ifdef PCIEIFC_SFIFO_ERR_CHK_EN
            total++;
            if ({ovf_err, udf_err} !== 2'b00) begin bad++; $display("FAIL async_rst_err_%0d got %b%b", pass, ovf_err, udf_err); end
`endif
            @(negedge clk);
            wen = 1'b0; ren = 1'b0;
            rst_n = 1'b1;
            cycle(1'b1, 8'h5A, 1'b0, 1'b0);
            total++;
            if ({dout, empty, count} !== {8'h5A, 1'b0, 3'd1})
                begin bad++; $display("FAIL post_rst_%0d got dout=%h e=%b cnt=%0d want 5a 0 1", pass, dout, empty, count); end
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_fill_full();
        test_full_push_pop();
        test_back_to_back();
        test_clr();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
